// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO widths, pointer type and Gray-code helpers
//
// Purpose: common definitions for the read-side and write-side pointer blocks.
// The Gray helpers take and return 32-bit values, so they work for any
// pointer width up to 32. Callers zero-extend on the way in and cast the
// result back down to their own width on the way out.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_PTR_WIDTH  = DEF_ADDR_WIDTH + 1;
  localparam int DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;

  typedef logic [DEF_PTR_WIDTH-1:0] ptr_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each output bit is the XOR of all Gray bits at or above it.
  // Doubling shifts build that prefix XOR in log2(32) steps.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// rtl/ptr_sync.sv - multi-flop synchronizer for a Gray pointer
//
// Purpose: carries a Gray-coded pointer into the local clock domain.
// The read and write sides both use this block. The first flop samples d
// directly, with no logic in front of it.
// Ports:
//   clk    in  local clock
//   rst_n  in  asynchronous active-low reset; clears every stage
//   d      in  WIDTH  pointer from the other clock domain
//   q      out WIDTH  synchronized pointer, STAGES edges after d
module ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/rptr_empty.sv
// rtl/rptr_empty.sv - async FIFO read pointer, empty/almost-empty, level, underflow
//
// Purpose: read-clock-domain half of the asynchronous FIFO.
// This block:
//   - synchronizes the Gray write pointer from the write domain
//   - advances the binary and Gray read pointers together
//   - registers the empty flag, almost-empty flag and fill level against the pointer value after this edge's pop
//   - holds a sticky underflow flag
// Ports:
//   rclk           in   read clock
//   rrst_n         in   asynchronous active-low reset
//   rinc           in   read request; pops only when not empty
//   gray_wr_ptr    in   Gray write pointer from the write domain
//   rempty         out  registered empty flag
//   ralmost_empty  out  registered, rlevel <= AEMPTY_THRESH
//   r_addr         out  memory read address (low bits of binary read pointer)
//   gray_rd_ptr    out  registered Gray read pointer toward the write domain
//   rlevel         out  registered entry count seen from the read domain
//   rerr_underflow out  sticky; set by a read request while empty
module rptr_empty
  import fifo_pkg::*;
#(
  parameter int RPTR_WIDTH    = 4,
  parameter int WPTR_WIDTH    = 4,
  parameter int ADDR_WIDTH    = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rinc,
  input  logic [WPTR_WIDTH-1:0] gray_wr_ptr,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [RPTR_WIDTH-1:0] gray_rd_ptr,
  output logic [RPTR_WIDTH-1:0] rlevel,
  output logic                  rerr_underflow
);

  localparam logic [RPTR_WIDTH-1:0] AE_THRESH = RPTR_WIDTH'(AEMPTY_THRESH);

  logic [WPTR_WIDTH-1:0] wq_gray;
  logic [RPTR_WIDTH-1:0] bn_rptr;
  logic [RPTR_WIDTH-1:0] bn_next;
  logic [RPTR_WIDTH-1:0] gray_next;
  logic [RPTR_WIDTH-1:0] wq_bin;
  logic [RPTR_WIDTH-1:0] level_next;
  logic                  pop;

  ptr_sync #(
    .WIDTH  (WPTR_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .d     (gray_wr_ptr),
    .q     (wq_gray)
  );

  // Flags and level are compared against the post-pop pointer.
  // Reading the last entry therefore raises rempty on that same edge.
  assign pop        = rinc & ~rempty;
  assign bn_next    = bn_rptr + RPTR_WIDTH'(pop);
  assign gray_next  = RPTR_WIDTH'(bin2gray(32'(bn_next)));
  assign wq_bin     = RPTR_WIDTH'(gray2bin(32'(wq_gray)));
  assign level_next = wq_bin - bn_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      bn_rptr        <= '0;
      gray_rd_ptr    <= '0;
      rempty         <= 1'b1;
      ralmost_empty  <= 1'b1;
      rlevel         <= '0;
      rerr_underflow <= 1'b0;
    end else begin
      bn_rptr       <= bn_next;
      gray_rd_ptr   <= gray_next;
      // Full Gray compare, MSB included: equal low bits with a different wrap bit mean full, not empty.
      rempty        <= (gray_next == wq_gray);
      rlevel        <= level_next;
      ralmost_empty <= (level_next <= AE_THRESH);
      if (rinc && rempty) rerr_underflow <= 1'b1;
    end
  end

  assign r_addr = bn_rptr[ADDR_WIDTH-1:0];

endmodule
